// File: rtl/loop_seq_iter.sv
// Clocked loop-index iterator: walks start_index toward limit by step, one index per accepted beat.
// Ports: clk/rst, start + start_index/limit/step/dir, abort, idx_ready/idx_valid/index, loop_active, done, reached, iter_count.
module loop_seq_iter #(
  parameter int IDX_W  = 4,
  parameter int STEP_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  start_index,
  input  logic [IDX_W-1:0]  limit,
  input  logic [STEP_W-1:0] step,
  input  logic              dir,
  input  logic              abort,
  input  logic              idx_ready,
  output logic              idx_valid,
  output logic [IDX_W-1:0]  index,
  output logic              loop_active,
  output logic              done,
  output logic              reached,
  output logic [IDX_W:0]    iter_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [IDX_W-1:0]  r_index;
  logic [IDX_W-1:0]  r_limit;
  logic [STEP_W-1:0] r_step;
  logic              r_dir;
  logic              r_reached;
  logic [IDX_W:0]    r_iter;

  logic              w_beat;
  logic [STEP_W-1:0] w_step_eff;
  logic [IDX_W:0]    w_step_ext;
  logic [IDX_W:0]    w_nxt;
  logic [IDX_W-1:0]  w_nxt_lo;
  logic              w_cb;
  logic              w_exit;
  logic              w_start_ok;

  // step of zero would never advance; treat it as one
  assign w_step_eff = (step == '0) ? STEP_W'(1) : step;
  assign w_step_ext = (IDX_W+1)'(r_step);

  assign w_beat = (r_state == S_RUN) && idx_ready;

  // extra MSB catches carry (up) or borrow (down)
  assign w_nxt    = r_dir ? ({1'b0, r_index} - w_step_ext)
                          : ({1'b0, r_index} + w_step_ext);
  assign w_cb     = w_nxt[IDX_W];
  assign w_nxt_lo = w_nxt[IDX_W-1:0];
  assign w_exit   = w_cb ||
                    (r_dir ? (w_nxt_lo <= r_limit)
                           : (w_nxt_lo >= r_limit));

  assign w_start_ok = dir ? (start_index > limit)
                          : (start_index < limit);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = w_start_ok ? S_RUN : S_FIN;
        end
      end
      S_RUN: begin
        if (abort || (w_beat && w_exit)) begin
          w_next = S_FIN;
        end
      end
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_index   <= '0;
      r_limit   <= '0;
      r_step    <= '0;
      r_dir     <= 1'b0;
      r_reached <= 1'b0;
      r_iter    <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_index   <= start_index;
            r_limit   <= limit;
            r_step    <= w_step_eff;
            r_dir     <= dir;
            r_iter    <= '0;
            r_reached <= !w_start_ok &&
                         (start_index == limit);
          end
        end
        S_RUN: begin
          if (w_beat) begin
            r_iter <= r_iter + (IDX_W+1)'(1);
          end
          if (abort) begin
            r_reached <= 1'b0;
          end else if (w_beat) begin
            if (w_exit) begin
              r_reached <= !w_cb &&
                           (w_nxt_lo == r_limit);
            end else begin
              r_index <= w_nxt_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign idx_valid   = (r_state == S_RUN);
  assign loop_active = (r_state == S_RUN);
  assign done        = (r_state == S_FIN);
  assign index       = r_index;
  assign reached     = r_reached;
  assign iter_count  = r_iter;

endmodule
